// File: rtl/mdsa_pkg.sv
// mdsa_pkg: shared state encoding, defaults and size helpers for the MDSA input loader
package mdsa_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int N_DEF = 3;
  localparam logic [DATA_W_DEF-1:0] PAD_DEF = '1;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_ARM, S_LAUNCH, S_WAIT_DONE} state_t;
  function automatic int elems(input int n);
    return n * n;
  endfunction
endpackage

// File: rtl/mdsa_frame_buffer.sv
// mdsa_frame_buffer: ELEMS x DATA_W register file with indexed write and flattened read-out
module mdsa_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int ELEMS = 9,
  parameter int IW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IW-1:0]           widx,
  input  logic [DATA_W-1:0]       wdata,
  output logic [ELEMS*DATA_W-1:0] flat
);
  logic [ELEMS*DATA_W-1:0] flat_q, flat_d;
  always_comb begin
    flat_d = flat_q;
    for (int k = 0; k < ELEMS; k++)
      if (we && widx == IW'(k)) flat_d[k*DATA_W +: DATA_W] = wdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flat_q <= '0;
    else flat_q <= flat_d;
  assign flat = flat_q;
endmodule

// File: rtl/mdsa_input_loader.sv
// mdsa_input_loader: assembles an N x N matrix from a valid/ready stream and launches one sort per frame
module mdsa_input_loader
  import mdsa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N = N_DEF,
  parameter logic [DATA_W-1:0] PAD = '1,
  localparam int ELEMS = elems(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    fsm_ready,
  input  logic                    fsm_done,
  output logic                    fsm_start,
  output logic                    load_en,
  output logic [ELEMS*DATA_W-1:0] matrix_flat,
  output logic                    busy,
  output logic                    short_frame,
  output logic [7:0]              frame_cnt
);
  localparam int IW = $clog2(ELEMS + 1);
  localparam logic [IW-1:0] LAST = IW'(ELEMS - 1);
  state_t state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [7:0] cnt_q, cnt_d;
  logic busy_q, busy_d, short_q, short_d, start_q, start_d;
  logic accept, we;
  assign in_ready = state_q == S_IDLE || state_q == S_FILL;
  assign accept = in_valid && in_ready;
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    busy_d = busy_q;
    short_d = short_q;
    cnt_d = cnt_q;
    start_d = 1'b0;
    we = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        we = 1'b1;
        index_d = index_q + 1'b1;
        busy_d = 1'b1;
        short_d = in_last && ELEMS > 1;
        state_d = ELEMS == 1 ? S_ARM : in_last ? S_PAD : S_FILL;
      end
      S_FILL: if (accept) begin
        we = 1'b1;
        index_d = index_q + 1'b1;
        state_d = index_q == LAST ? S_ARM : in_last ? S_PAD : S_FILL;
        short_d = short_q || (in_last && index_q != LAST);
      end
      S_PAD: begin
        we = 1'b1;
        index_d = index_q + 1'b1;
        state_d = index_q == LAST ? S_ARM : S_PAD;
      end
      S_ARM: begin
        start_d = fsm_ready;
        state_d = fsm_ready ? S_LAUNCH : S_ARM;
      end
      S_LAUNCH: begin
        cnt_d = cnt_q + 8'd1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (fsm_done) begin
        busy_d = 1'b0;
        index_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      short_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      short_q <= short_d;
      start_q <= start_d;
    end
  // PAD slots reuse the same write port as accepted beats
  mdsa_frame_buffer #(.DATA_W(DATA_W), .ELEMS(ELEMS), .IW(IW)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .widx(index_q),
    .wdata(state_q == S_PAD ? PAD : in_data),
    .flat(matrix_flat)
  );
  assign fsm_start = start_q;
  assign load_en = start_q;
  assign busy = busy_q;
  assign short_frame = short_q;
  assign frame_cnt = cnt_q;
endmodule
